tribus_arb: RTL
===============

TRIBUS_ARB -- requirements
Module: tribus_arb

Interface
REQ-001 Parameter N, default 4: number of requesting channels, 2..16.
REQ-002 Parameter W, default 8: bus data width, 1..64.
REQ-003 Parameter MAXG, default 16: grant cycle limit, 2..256; used only when TRIBUS_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 clrn  input  1  asynchronous active-low reset (clear).
REQ-006 req  input  N  req[i]=1: channel i requests the bus.
REQ-007 d  input  N*W  channel i drive data in d[i*W+W-1 : i*W].
REQ-008 bus  inout  W  shared tri-state bus; per-channel tri-state buffers gated by registered grant.
REQ-009 grant  output  N  one-hot or zero; grant[i]=1: channel i owns the bus this cycle.
REQ-010 owner  output  max(1,clog2(N))  index of the current or last owner.
REQ-011 busy  output  1  equals |grant.

Function
REQ-012 FSM states SHALL be IDLE, GRANT and TURN, state-encoded and registered.
REQ-013 bus SHALL equal d slice of channel i when grant[i]=1, and high-impedance on all bits when grant=0.
REQ-014 No two buffers SHALL ever enable in the same cycle; grant SHALL come only from registers, never from decoding req combinationally.
REQ-015 IDLE or TURN with req!=0: winner = first set req bit scanning upward, with wrap, from channel (ptr+1) mod N; next edge: state GRANT, grant one-hot on winner, owner and ptr set to winner.
REQ-016 IDLE or TURN with req=0: next state IDLE, grant=0.
REQ-017 Grant latency SHALL be exactly one cycle from the edge first sampling req[i]=1 when the FSM is in IDLE.
REQ-018 GRANT with req[owner]=1 and no timeout: state, grant and owner SHALL hold.
REQ-019 GRANT with req[owner]=0 sampled: next state TURN, grant=0.
REQ-020 TURN SHALL last exactly one cycle with bus high-impedance, giving a minimum one-cycle gap between any two owners, including re-grant to the same channel.
REQ-021 A req pulse that drops before being sampled in IDLE or TURN SHALL produce no grant.
REQ-022 req changes on non-owner channels during GRANT SHALL be ignored until the next arbitration.
REQ-023 With N not a power of two, owner SHALL never exceed N-1, and the wrap SHALL go from N-1 to 0.
REQ-024 d SHALL be a pure data path, with no effect on FSM state.

Reset
REQ-025 On clrn=0, regardless of clk: state=IDLE, grant=0, busy=0, owner=0, ptr=N-1 (so channel 0 has first priority), timeout counter=0, and bus high-impedance immediately.
REQ-026 clrn asserted mid-GRANT SHALL release the bus asynchronously with no turnaround cycle; arbitration SHALL resume on the first rising edge after clrn rises.

Configuration
REQ-027 Macro TRIBUS_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-028 With TRIBUS_TIMEOUT_EN defined, when the count reaches MAXG-1 while in GRANT, the next state SHALL be TURN even if req[owner]=1.
REQ-029 With TRIBUS_TIMEOUT_EN defined, a preempted channel that still requests SHALL rejoin arbitration with lowest priority, since ptr equals its index.
REQ-030 With TRIBUS_TIMEOUT_EN defined, a timeout and a req[owner] drop in the same cycle SHALL produce a single TURN.
REQ-031 Macro TRIBUS_TIMEOUT_EN undefined: no counter SHALL exist, a grant SHALL hold indefinitely while req[owner]=1, and MAXG SHALL be ignored.

Verification
REQ-032 Reset release, req=4'b0001 for 3 cycles: grant=0001 from cycle 2, bus=d[7:0]; req drop gives one TURN cycle with bus Z, then IDLE.
REQ-033 req=4'b1111 held, timeout off, each channel dropping req after 2 grant cycles: grant order 0,1,2,3, one Z cycle between each.
REQ-034 Owner 2 active, req[1] and req[3] rise: after owner 2 releases, channel 3 wins; owner=3.
REQ-035 clrn pulsed low mid-GRANT: grant=0 and bus=Z within the reset pulse, with no clk edge needed; after release with req=0001, grant=0001 one cycle later.
REQ-036 TRIBUS_TIMEOUT_EN defined, MAXG=4, req=4'b0011 held: channel 0 owns 4 cycles, TURN, channel 1 owns 4 cycles, TURN, channel 0 again.
REQ-037 Every cycle, random req with N=3 and W=5: assert grant is one-hot or zero, owner<3, and no X on bus while busy=1.

Source files
------------

// File: rtl/tribus_arb.sv
// tribus_arb: round-robin arbiter handing one shared tri-state bus to N channels.
// Define TRIBUS_TIMEOUT_EN to preempt an owner after MAXG grant cycles.
module tribus_arb #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MAXG = 16
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         d,
  inout  wire  [W-1:0]           bus,
  output logic [N-1:0]           grant,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   busy
);

  localparam int unsigned OW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("tribus_arb: N must be within 2..16");
  end
  if (W < 1 || W > 64) begin : g_bad_w
    $error("tribus_arb: W must be within 1..64");
  end
  if (MAXG < 2 || MAXG > 256) begin : g_bad_maxg
    $error("tribus_arb: MAXG must be within 2..256");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  ptr_q, ptr_d;
  logic           win_valid;
  logic [OW-1:0]  win_idx;
  logic           timeout;
  logic [W-1:0]   bus_data;

`ifdef TRIBUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout = (state_q == StGrant) && (cnt_q == 8'(MAXG - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Scan upward from ptr+1 with wrap; sum never exceeds 2N-1 so OW+1 bits suffice.
  always_comb begin
    logic [OW:0]   sum;
    logic [OW-1:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= int'(N); k++) begin
      sum = {1'b0, ptr_q} + (OW+1)'(k);
      if (sum >= (OW+1)'(N)) begin
        sum = sum - (OW+1)'(N);
      end
      cand = sum[OW-1:0];
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef TRIBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle, StTurn: begin
        grant_d = '0;
        if (win_valid) begin
          state_d          = StGrant;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          ptr_d            = win_idx;
`ifdef TRIBUS_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        // A release and a timeout in the same cycle still yield one TURN.
        if (!req[owner_q] || timeout) begin
          state_d = StTurn;
          grant_d = '0;
        end else begin
`ifdef TRIBUS_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // grant_q is one-hot or zero, so the AND-OR acts as the per-channel buffer select.
  always_comb begin
    bus_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_q[i]) begin
        bus_data = bus_data | d[i*W +: W];
      end
    end
  end

  assign bus   = busy ? bus_data : {W{1'bz}};
  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = |grant_q;

endmodule
